// File: rtl/cordic_vector_mc_pkg.sv
// Shared types and sizing helpers for the multi-channel CORDIC vectoring block.
package cordic_vector_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  // Datapath width: two guard bits cover the CORDIC gain and the sqrt(2) corner growth
  function automatic int guard_width(input int bit_width);
    return bit_width + 2;
  endfunction

  // Counter width able to hold 0..count-1, never narrower than one bit
  function automatic int cnt_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/cordic_vector_mc_micro_rot.sv
// One combinational CORDIC vectoring micro-rotation with a run-time shift amount.
module cordic_micro_rot
  import cordic_vector_mc_pkg::*;
#(
  parameter int W       = guard_width(24),
  parameter int K_WIDTH = 5
) (
  input  logic signed [W-1:0]   i_x,
  input  logic signed [W-1:0]   i_y,
  input  logic signed [W-1:0]   i_z,
  input  logic signed [W-1:0]   i_angle,
  input  logic [K_WIDTH-1:0]    i_k,
  output logic signed [W-1:0]   o_x,
  output logic signed [W-1:0]   o_y,
  output logic signed [W-1:0]   o_z
);

  logic signed [W-1:0] w_xShift;
  logic signed [W-1:0] w_yShift;

  // Rotate toward the positive x axis; the sign of y picks the direction and both shifts use pre-update values
  always_comb begin
    w_xShift = i_x >>> i_k;
    w_yShift = i_y >>> i_k;
    if (!i_y[W-1]) begin
      o_x = i_x + w_yShift;
      o_y = i_y - w_xShift;
      o_z = i_z + i_angle;
    end else begin
      o_x = i_x - w_yShift;
      o_y = i_y + w_xShift;
      o_z = i_z - i_angle;
    end
  end

endmodule

// File: rtl/cordic_vector_mc.sv
// Multi-channel iterative CORDIC vectoring: one shared micro-rotation stage is
// time-multiplexed across NUM_CH (sin, cos) pairs to produce phase and magnitude.
module cordic_vector_mc
  import cordic_vector_mc_pkg::*;
#(
  parameter int BIT_WIDTH       = 24,
  parameter int ITERATIONS      = 24,
  parameter int NUM_CH          = 2,
  parameter int PHASE_FRAC_BITS = BIT_WIDTH - 3
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [NUM_CH*BIT_WIDTH-1:0]      sin_i,
  input  logic [NUM_CH*BIT_WIDTH-1:0]      cos_i,
  input  logic [ITERATIONS*BIT_WIDTH-1:0]  angle_table_i,
  output logic [NUM_CH*BIT_WIDTH-1:0]      phi_o,
  output logic [NUM_CH*(BIT_WIDTH+2)-1:0]  mag_o,
  output logic                             valid_o,
  input  logic                             ready_i
);

  localparam int GW  = guard_width(BIT_WIDTH);
  localparam int CHW = cnt_width(NUM_CH);
  localparam int KW  = cnt_width(ITERATIONS);

  if (ITERATIONS < 1 || ITERATIONS > BIT_WIDTH || NUM_CH < 1 ||
      PHASE_FRAC_BITS > BIT_WIDTH - 3) begin : g_bad_params
    $error("cordic_vector_mc: illegal parameter combination");
  end

  state_t                        r_state;
  logic [CHW-1:0]                r_ch;
  logic [KW-1:0]                 r_k;
  logic [NUM_CH*BIT_WIDTH-1:0]   r_sinBuf;
  logic [NUM_CH*BIT_WIDTH-1:0]   r_cosBuf;
  logic signed [GW-1:0]          r_x;
  logic signed [GW-1:0]          r_y;
  logic signed [GW-1:0]          r_z;
  logic                          r_zeroIn;
  logic [NUM_CH*BIT_WIDTH-1:0]   r_phi;
  logic [NUM_CH*GW-1:0]          r_mag;
  logic                          r_valid;

  logic signed [BIT_WIDTH-1:0]   w_sinCh;
  logic signed [BIT_WIDTH-1:0]   w_cosCh;
  logic signed [BIT_WIDTH-1:0]   w_table0;
  logic signed [BIT_WIDTH-1:0]   w_tableK;
  logic signed [GW-1:0]          w_sinExt;
  logic signed [GW-1:0]          w_cosExt;
  logic signed [GW-1:0]          w_halfPi;
  logic signed [GW-1:0]          w_angle;
  logic signed [GW-1:0]          w_xLoad;
  logic signed [GW-1:0]          w_yLoad;
  logic signed [GW-1:0]          w_zLoad;
  logic signed [GW-1:0]          w_xNext;
  logic signed [GW-1:0]          w_yNext;
  logic signed [GW-1:0]          w_zNext;

  assign ready_o = (r_state == IDLE);
  assign phi_o   = r_phi;
  assign mag_o   = r_mag;
  assign valid_o = r_valid;

  // Select the active channel and table entry, sign-extending into the guarded width
  always_comb begin
    w_sinCh  = r_sinBuf[r_ch*BIT_WIDTH +: BIT_WIDTH];
    w_cosCh  = r_cosBuf[r_ch*BIT_WIDTH +: BIT_WIDTH];
    w_table0 = angle_table_i[BIT_WIDTH-1:0];
    w_tableK = angle_table_i[r_k*BIT_WIDTH +: BIT_WIDTH];
    w_sinExt = {{2{w_sinCh[BIT_WIDTH-1]}}, w_sinCh};
    w_cosExt = {{2{w_cosCh[BIT_WIDTH-1]}}, w_cosCh};
    w_halfPi = {w_table0[BIT_WIDTH-1], w_table0, 1'b0};
    w_angle  = {{2{w_tableK[BIT_WIDTH-1]}}, w_tableK};
  end

  // Quadrant pre-rotation folds the left half-plane onto the right so the full (-pi, pi] range converges
  always_comb begin
    w_xLoad = w_cosExt;
    w_yLoad = w_sinExt;
    w_zLoad = '0;
    if (w_cosExt[GW-1]) begin
      if (!w_sinExt[GW-1]) begin
        w_xLoad = w_sinExt;
        w_yLoad = -w_cosExt;
        w_zLoad = w_halfPi;
      end else begin
        w_xLoad = -w_sinExt;
        w_yLoad = w_cosExt;
        w_zLoad = -w_halfPi;
      end
    end
  end

  cordic_micro_rot #(
    .W       (GW),
    .K_WIDTH (KW)
  ) u_microRot (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_angle (w_angle),
    .i_k     (r_k),
    .o_x     (w_xNext),
    .o_y     (w_yNext),
    .o_z     (w_zNext)
  );

  // Frame sequencer: capture, then LOAD/ITER per channel, then hold results until downstream accepts
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state  <= IDLE;
      r_ch     <= '0;
      r_k      <= '0;
      r_sinBuf <= '0;
      r_cosBuf <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_zeroIn <= 1'b0;
      r_phi    <= '0;
      r_mag    <= '0;
      r_valid  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_sinBuf <= sin_i;
            r_cosBuf <= cos_i;
            r_ch     <= '0;
            r_state  <= LOAD;
          end
        end
        LOAD: begin
          r_x      <= w_xLoad;
          r_y      <= w_yLoad;
          r_z      <= w_zLoad;
          r_zeroIn <= (w_sinCh == '0) && (w_cosCh == '0);
          r_k      <= '0;
          r_state  <= ITER;
        end
        ITER: begin
          r_x <= w_xNext;
          r_y <= w_yNext;
          r_z <= w_zNext;
          r_k <= r_k + 1'b1;
          if (r_k == KW'(ITERATIONS - 1)) begin
            // A zero vector would otherwise accumulate the whole table into z, so its phase is forced to 0
            r_phi[r_ch*BIT_WIDTH +: BIT_WIDTH] <= r_zeroIn ? '0 : w_zNext[BIT_WIDTH-1:0];
            r_mag[r_ch*GW +: GW]               <= w_xNext;
            if (r_ch == CHW'(NUM_CH - 1)) begin
              r_state <= DONE;
              r_valid <= 1'b1;
            end else begin
              r_ch    <= r_ch + 1'b1;
              r_state <= LOAD;
            end
          end
        end
        DONE: begin
          if (ready_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
